// File: rtl/id_pkg.sv
// Shared definitions for the instruction decode buffer.
// Field positions follow the classic 32-bit MIPS-style encoding. The entry
// struct carries its pc at the widest supported width. Narrower PC_W values
// are zero-extended on write and truncated on read.
package id_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_MAX_W  = 64;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SA_LSB     = 6;
  localparam int REG_W      = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int INDEX_LSB  = 0;
  localparam int INDEX_W    = 26;
  localparam int CODE_LSB   = 6;
  localparam int CODE_W     = 20;
  localparam int SEL_LSB    = 0;
  localparam int SEL_W      = 3;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  // Loads and stores are recognised by the top three opcode bits.
  localparam logic [2:0] OPGRP_LOAD  = 3'b100;
  localparam logic [2:0] OPGRP_STORE = 3'b101;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
  } id_entry_t;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ)   || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/id_field_decode.sv
// Pure combinational field slicer for the buffer head.
// When the head is not valid, every field is forced to zero. This keeps
// downstream logic from seeing stale storage contents.
// Optional feature macro: ID_DECODE_CLASS_EN adds the opcode class flags.
module id_field_decode
  import id_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic [31:0] imm_sext,
  output logic [31:0] imm_zext,
  output logic [25:0] instIndex,
  output logic [19:0] code,
  output logic [2:0]  sel
`ifdef ID_DECODE_CLASS_EN
  ,
  output logic        is_rtype,
  output logic        is_jump,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store
`endif
);

  // Slice and extend the head instruction, zero when nothing is buffered.
  always_comb begin
    opcode    = '0;
    funct     = '0;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    sa        = '0;
    imm       = '0;
    imm_sext  = '0;
    imm_zext  = '0;
    instIndex = '0;
    code      = '0;
    sel       = '0;
    if (valid) begin
      opcode    = instr[OPCODE_LSB +: OPCODE_W];
      funct     = instr[FUNCT_LSB  +: FUNCT_W];
      rs        = instr[RS_LSB     +: REG_W];
      rt        = instr[RT_LSB     +: REG_W];
      rd        = instr[RD_LSB     +: REG_W];
      sa        = instr[SA_LSB     +: REG_W];
      imm       = instr[IMM_LSB    +: IMM_W];
      imm_sext  = {{(32-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
      imm_zext  = {{(32-IMM_W){1'b0}}, instr[IMM_LSB +: IMM_W]};
      instIndex = instr[INDEX_LSB  +: INDEX_W];
      code      = instr[CODE_LSB   +: CODE_W];
      sel       = instr[SEL_LSB    +: SEL_W];
    end
  end

`ifdef ID_DECODE_CLASS_EN
  // Classify the head opcode. The valid gate matters because a zero opcode
  // would otherwise read as an R-type.
  always_comb begin
    is_rtype  = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    if (valid) begin
      is_rtype  = (instr[OPCODE_LSB +: OPCODE_W] == OP_SPECIAL);
      is_jump   = is_jump_op(instr[OPCODE_LSB +: OPCODE_W]);
      is_branch = is_branch_op(instr[OPCODE_LSB +: OPCODE_W]);
      is_load   = (instr[31:29] == OPGRP_LOAD);
      is_store  = (instr[31:29] == OPGRP_STORE);
    end
  end
`endif

endmodule

// File: rtl/id_decode_buf.sv
// Instruction decode buffer: a DEPTH-entry circular FIFO between fetch and
// execute, with the head entry decoded combinationally.
// A push becomes visible one edge later. There is no bypass from input to
// output. in_ready depends only on occupancy, so a full buffer refuses a push
// even in a cycle where it also pops.
// Optional feature macro: ID_DECODE_CLASS_EN adds the opcode class outputs.
module id_decode_buf
  import id_pkg::*;
#(
  parameter int DEPTH = 4,   // legal: 2, 4, 8
  parameter int PC_W  = 32
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instruction,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               opcode,
  output logic [5:0]               funct,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               sa,
  output logic [15:0]              imm,
  output logic [31:0]              imm_sext,
  output logic [31:0]              imm_zext,
  output logic [25:0]              instIndex,
  output logic [19:0]              code,
  output logic [2:0]               sel,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
`ifdef ID_DECODE_CLASS_EN
  ,
  output logic                     is_rtype,
  output logic                     is_jump,
  output logic                     is_branch,
  output logic                     is_load,
  output logic                     is_store
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
    $error("id_decode_buf: DEPTH must be 2, 4 or 8");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          push;
  logic          pop;
  id_entry_t     wr_entry;
  id_entry_t     head;
  id_entry_t     mem [DEPTH];

  assign in_ready  = (occ < CW'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = occ;

  // Pack the incoming instruction and pc into a storage entry.
  always_comb begin
    wr_entry       = '0;
    wr_entry.instr = instruction;
    wr_entry.pc    = PC_MAX_W'(in_pc);
  end

  // Update the pointers and occupancy. Reset beats flush, and flush beats push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Write the storage array. It is never cleared; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= wr_entry;
  end

  assign head   = mem[rd_ptr];
  assign out_pc = out_valid ? PC_W'(head.pc) : '0;

  id_field_decode u_decode (
    .instr     (head.instr),
    .valid     (out_valid),
    .opcode    (opcode),
    .funct     (funct),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .sa        (sa),
    .imm       (imm),
    .imm_sext  (imm_sext),
    .imm_zext  (imm_zext),
    .instIndex (instIndex),
    .code      (code),
    .sel       (sel)
`ifdef ID_DECODE_CLASS_EN
    ,
    .is_rtype  (is_rtype),
    .is_jump   (is_jump),
    .is_branch (is_branch),
    .is_load   (is_load),
    .is_store  (is_store)
`endif
  );

endmodule

// File: tb/tb_id_decode_buf.sv
// Bench for id_decode_buf. It runs two instances on shared stimulus: DEPTH=4
// for the directed scenarios and DEPTH=8 for the random FIFO-order run. The
// reference is a queue plus field arithmetic taken from the instruction encoding.
module tb_id_decode_buf;

`ifdef ID_DECODE_CLASS_EN
  localparam int FW = 166;
`else
  localparam int FW = 161;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instruction, in_pc;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_imm_sext, a_imm_zext;
  logic [5:0]  a_opcode, a_funct;
  logic [4:0]  a_rs, a_rt, a_rd, a_sa;
  logic [15:0] a_imm;
  logic [25:0] a_instIndex;
  logic [19:0] a_code;
  logic [2:0]  a_sel, a_count;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_imm_sext, b_imm_zext;
  logic [5:0]  b_opcode, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd, b_sa;
  logic [15:0] b_imm;
  logic [25:0] b_instIndex;
  logic [19:0] b_code;
  logic [2:0]  b_sel;
  logic [3:0]  b_count;

`ifdef ID_DECODE_CLASS_EN
  logic a_is_rtype, a_is_jump, a_is_branch, a_is_load, a_is_store;
  logic b_is_rtype, b_is_jump, b_is_branch, b_is_load, b_is_store;
`endif

  logic [FW-1:0] a_all, b_all;
  assign a_all = {a_opcode, a_funct, a_rs, a_rt, a_rd, a_sa, a_imm, a_imm_sext, a_imm_zext,
                  a_instIndex, a_code, a_sel
`ifdef ID_DECODE_CLASS_EN
                  , a_is_rtype, a_is_jump, a_is_branch, a_is_load, a_is_store
`endif
                  };
  assign b_all = {b_opcode, b_funct, b_rs, b_rt, b_rd, b_sa, b_imm, b_imm_sext, b_imm_zext,
                  b_instIndex, b_code, b_sel
`ifdef ID_DECODE_CLASS_EN
                  , b_is_rtype, b_is_jump, b_is_branch, b_is_load, b_is_store
`endif
                  };

  id_decode_buf #(.DEPTH(4), .PC_W(32)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instruction(instruction), .in_pc(in_pc), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_out_pc), .opcode(a_opcode), .funct(a_funct),
    .rs(a_rs), .rt(a_rt), .rd(a_rd), .sa(a_sa), .imm(a_imm), .imm_sext(a_imm_sext),
    .imm_zext(a_imm_zext), .instIndex(a_instIndex), .code(a_code), .sel(a_sel),
    .flush(flush), .count(a_count)
`ifdef ID_DECODE_CLASS_EN
    , .is_rtype(a_is_rtype), .is_jump(a_is_jump), .is_branch(a_is_branch),
    .is_load(a_is_load), .is_store(a_is_store)
`endif
  );

  id_decode_buf #(.DEPTH(8), .PC_W(32)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instruction(instruction), .in_pc(in_pc), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .opcode(b_opcode), .funct(b_funct),
    .rs(b_rs), .rt(b_rt), .rd(b_rd), .sa(b_sa), .imm(b_imm), .imm_sext(b_imm_sext),
    .imm_zext(b_imm_zext), .instIndex(b_instIndex), .code(b_code), .sel(b_sel),
    .flush(flush), .count(b_count)
`ifdef ID_DECODE_CLASS_EN
    , .is_rtype(b_is_rtype), .is_jump(b_is_jump), .is_branch(b_is_branch),
    .is_load(b_is_load), .is_store(b_is_store)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Expected decoded fields, derived arithmetically from the instruction word.
  function automatic logic [FW-1:0] exp_all(input logic [31:0] w);
    int unsigned op, im;
    logic [31:0] sx;
    op = w >> 26;
    im = w % 65536;
    sx = (im >= 32768) ? im + 32'hFFFF_0000 : im;
    exp_all = {6'(op), 6'(w % 64), 5'((w >> 21) % 32), 5'((w >> 16) % 32),
               5'((w >> 11) % 32), 5'((w >> 6) % 32), 16'(im), sx, 32'(im),
               26'(w % 32'h0400_0000), 20'((w >> 6) % 32'h0010_0000), 3'(w % 8)
`ifdef ID_DECODE_CLASS_EN
               , (op == 0), (op == 2 || op == 3), (op == 1 || (op >= 4 && op <= 7)),
               (op / 8 == 4), (op / 8 == 5)
`endif
               };
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; instruction = '0; in_pc = '0;
    tick(); tick();
    rst = 0;
    #1;
    n_total++; if (a_count !== 3'd0) $display("FAIL reset_count got %0d want 0", a_count); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_in_ready); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else n_pass++;
    n_total++; if (a_all !== '0) $display("FAIL reset_fields got %h want 0", a_all); else n_pass++;
    n_total++; if (a_out_pc !== 32'd0) $display("FAIL reset_out_pc got %h want 0", a_out_pc); else n_pass++;
  endtask

  task automatic test_single;
    in_valid = 1; instruction = 32'h8C22_FFFC; in_pc = 32'h0040_0000; out_ready = 1;
    #1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL single_no_bypass got %b want 0", a_out_valid); else n_pass++;
    tick();
    in_valid = 0;
    #1;
    n_total++; if (a_out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", a_out_valid); else n_pass++;
    n_total++; if (a_opcode !== 6'h23) $display("FAIL single_opcode got %h want 23", a_opcode); else n_pass++;
    n_total++; if (a_rs !== 5'd1 || a_rt !== 5'd2) $display("FAIL single_rs_rt got %0d/%0d want 1/2", a_rs, a_rt); else n_pass++;
    n_total++; if (a_imm_sext !== 32'hFFFF_FFFC) $display("FAIL single_imm_sext got %h want fffffffc", a_imm_sext); else n_pass++;
    n_total++; if (a_imm_zext !== 32'h0000_FFFC) $display("FAIL single_imm_zext got %h want 0000fffc", a_imm_zext); else n_pass++;
    n_total++; if (a_out_pc !== 32'h0040_0000) $display("FAIL single_out_pc got %h want 00400000", a_out_pc); else n_pass++;
    n_total++; if (a_all !== exp_all(32'h8C22_FFFC)) $display("FAIL single_fields got %h want %h", a_all, exp_all(32'h8C22_FFFC)); else n_pass++;
    tick();
    out_ready = 0;
    #1;
    n_total++; if (a_out_valid !== 1'b0 || a_count !== 3'd0) $display("FAIL single_popped valid=%b count=%0d want 0/0", a_out_valid, a_count); else n_pass++;
  endtask

  task automatic test_fill_drain;
    logic [31:0] ins [5];
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ins[i] = $urandom;
      in_valid = 1; instruction = ins[i]; in_pc = 32'h1000 + 4 * i;
      #1;
      n_total++; if (a_in_ready !== (i < 4)) $display("FAIL fill_in_ready[%0d] got %b want %b", i, a_in_ready, (i < 4)); else n_pass++;
      tick();
    end
    in_valid = 0;
    #1;
    n_total++; if (a_count !== 3'd4 || a_in_ready !== 1'b0) $display("FAIL fill_full count=%0d rdy=%b want 4/0", a_count, a_in_ready); else n_pass++;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h1000 + 4 * i) $display("FAIL drain_pc[%0d] got %b/%h want 1/%h", i, a_out_valid, a_out_pc, 32'h1000 + 4 * i); else n_pass++;
      n_total++; if (a_all !== exp_all(ins[i])) $display("FAIL drain_fields[%0d] got %h want %h", i, a_all, exp_all(ins[i])); else n_pass++;
      tick();
    end
    out_ready = 0;
    #1;
    n_total++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) $display("FAIL drain_empty count=%0d valid=%b want 0/0", a_count, a_out_valid); else n_pass++;
  endtask

  task automatic test_full_push_pop;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; instruction = 32'h0000_0100 + i; in_pc = 32'h2000 + 4 * i;
      tick();
    end
    instruction = 32'hDEAD_BEEF; in_pc = 32'h2FFC; out_ready = 1;
    #1;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL fullpp_in_ready got %b want 0", a_in_ready); else n_pass++;
    tick();
    in_valid = 0; out_ready = 0;
    #1;
    n_total++; if (a_count !== 3'd3) $display("FAIL fullpp_count got %0d want 3", a_count); else n_pass++;
    n_total++; if (a_out_pc !== 32'h2004) $display("FAIL fullpp_head got %h want 00002004", a_out_pc); else n_pass++;
  endtask

  task automatic test_flush;
    out_ready = 1;
    tick();
    out_ready = 0;
    #1;
    n_total++; if (a_count !== 3'd2) $display("FAIL flush_pre_count got %0d want 2", a_count); else n_pass++;
    flush = 1; in_valid = 1; out_ready = 1; instruction = 32'h1234_5678; in_pc = 32'h3000;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    #1;
    n_total++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) $display("FAIL flush_count count=%0d valid=%b want 0/0", a_count, a_out_valid); else n_pass++;
    n_total++; if (a_all !== '0 || a_out_pc !== 32'd0) $display("FAIL flush_zero fields=%h pc=%h want 0", a_all, a_out_pc); else n_pass++;
    tick();
    n_total++; if (a_count !== 3'd0 || a_in_ready !== 1'b1) $display("FAIL flush_dropped count=%0d rdy=%b want 0/1", a_count, a_in_ready); else n_pass++;
  endtask

  task automatic test_rst_mid;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; instruction = $urandom; in_pc = 32'h4000 + 4 * i;
      tick();
    end
    in_valid = 0;
    #1;
    n_total++; if (a_count !== 3'd3) $display("FAIL rstmid_pre_count got %0d want 3", a_count); else n_pass++;
    rst = 1; in_valid = 1; out_ready = 1;
    tick();
    rst = 0; in_valid = 0; out_ready = 0;
    #1;
    n_total++; if (a_count !== 3'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("FAIL rstmid_state count=%0d rdy=%b valid=%b want 0/1/0", a_count, a_in_ready, a_out_valid); else n_pass++;
    in_valid = 1; instruction = 32'h0000_0020; in_pc = 32'h80;
    tick();
    in_valid = 0;
    #1;
    n_total++; if (a_funct !== 6'h20) $display("FAIL rstmid_funct got %h want 20", a_funct); else n_pass++;
    n_total++; if (a_all !== exp_all(32'h0000_0020)) $display("FAIL rstmid_fields got %h want %h", a_all, exp_all(32'h0000_0020)); else n_pass++;
`ifdef ID_DECODE_CLASS_EN
    n_total++; if (a_is_rtype !== 1'b1) $display("FAIL rstmid_rtype got %b want 1", a_is_rtype); else n_pass++;
`endif
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_random;
    ent_t q[$];
    ent_t e;
    int   accepted;
    int   max_occ;
    logic do_push, do_pop;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    rst = 0;
    accepted = 0;
    max_occ  = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid    = ($urandom % 100) < ((c < 100) ? 70 : 30);
      out_ready   = ($urandom % 100) < ((c < 100) ? 35 : 70);
      instruction = $urandom;
      in_pc       = $urandom;
      #1;
      n_total++; if (b_count !== 4'(q.size())) $display("FAIL rand_count[%0d] got %0d want %0d", c, b_count, q.size()); else n_pass++;
      n_total++; if (b_count > 4'd8) $display("FAIL rand_bound[%0d] got %0d want <=8", c, b_count); else n_pass++;
      n_total++; if (b_in_ready !== (q.size() < 8) || b_out_valid !== (q.size() != 0)) $display("FAIL rand_hs[%0d] rdy=%b valid=%b want %b/%b", c, b_in_ready, b_out_valid, (q.size() < 8), (q.size() != 0)); else n_pass++;
      if (q.size() != 0) begin
        n_total++; if (b_out_pc !== q[0].pc || b_all !== exp_all(q[0].instr)) $display("FAIL rand_head[%0d] pc=%h want %h fields=%h want %h", c, b_out_pc, q[0].pc, b_all, exp_all(q[0].instr)); else n_pass++;
      end else begin
        n_total++; if (b_out_pc !== 32'd0 || b_all !== '0) $display("FAIL rand_empty_zero[%0d] pc=%h fields=%h want 0", c, b_out_pc, b_all); else n_pass++;
      end
      do_push = in_valid && (q.size() < 8);
      do_pop  = out_ready && (q.size() != 0);
      e.instr = instruction;
      e.pc    = in_pc;
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        accepted++;
      end
      if (q.size() > max_occ) max_occ = q.size();
    end
    in_valid = 0; out_ready = 0;
    n_total++; if (accepted <= 16 || max_occ != 8) $display("FAIL rand_coverage accepted=%0d max=%0d want >16/8", accepted, max_occ); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
